// File: rtl/instr_loader_pkg.sv
// Shared types and default sizing for the instruction-memory loader.
package instr_loader_pkg;

  localparam int unsigned ADDR_W_DEF    = 8;
  localparam int unsigned MAX_WORDS_DEF = 256;
  localparam int unsigned TIMEOUT_DEF   = 1024;
  localparam int unsigned WORD_BYTES    = 4;
  localparam int unsigned WORD_W        = 8 * WORD_BYTES;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/loader_byte_packer.sv
// Packs accepted stream bytes little-endian into one instruction word.
module loader_byte_packer
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              clear,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  localparam int unsigned CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] word_q;

  // word already includes the byte being accepted, so the FSM can latch it on the final handshake
  always_comb begin
    word      = word_q;
    word_full = 1'b0;
    if (accept) begin
      word[{cnt_q, 3'b000} +: 8] = byte_in;
      word_full                  = (cnt_q == CNT_W'(WORD_BYTES - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (accept) begin
      cnt_q  <= cnt_q + CNT_W'(1);
      word_q <= word;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Byte-stream loader for the core's instruction memory; holds the core in reset until a full image lands.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] checksum
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT);

  state_e            state;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  len_q;
  logic [TO_W-1:0]   to_cnt;
  logic              accept;
  logic              pk_clear;
  logic [WORD_W-1:0] pk_word;
  logic              pk_full;

  // byte_ready is a registered copy of the RECV state, so accept has no valid-to-ready loop
  assign accept   = byte_valid && byte_ready;
  assign pk_clear = (state != RECV);
  assign cnt_inc  = word_cnt + CNT_W'(1);

  loader_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .clear     (pk_clear),
    .byte_in   (byte_in),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_hold  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      checksum   <= '0;
      word_cnt   <= '0;
      len_q      <= '0;
      to_cnt     <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            done      <= 1'b0;
            err       <= 1'b0;
            checksum  <= '0;
            word_cnt  <= '0;
            core_hold <= 1'b1;
            if (load_len == '0 || load_len > CNT_W'(MAX_WORDS)) begin
              err <= 1'b1;
            end else begin
              len_q      <= load_len;
              to_cnt     <= '0;
              state      <= RECV;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
            end
          end
        end
        RECV: begin
          if (accept) begin
            to_cnt <= '0;
            if (pk_full) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt[ADDR_W-1:0];
              imem_wdata <= pk_word;
              byte_ready <= 1'b0;
              state      <= WRITE;
            end
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            // abort: partial word is dropped by the packer clear, written words stay
            err        <= 1'b1;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            to_cnt     <= '0;
            state      <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        WRITE: begin
          checksum <= checksum ^ imem_wdata;
          word_cnt <= cnt_inc;
          if (cnt_inc == len_q) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            core_hold <= 1'b0;
            state     <= DONE;
          end else begin
            byte_ready <= 1'b1;
            to_cnt     <= '0;
            state      <= RECV;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: packing, sequencing, length checks, timeout and reset recovery.
module tb_instr_loader;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TIMEOUT = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic [7:0]        byte_in = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       checksum;

  int vectors     = 0;
  int miscompares = 0;
  int we_count    = 0;

  instr_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_len   (load_len),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we === 1'b1) we_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int len);
    load_start = 1'b1;
    load_len   = (ADDR_W + 1)'(len);
    tick();
    load_start = 1'b0;
  endtask

  // Hold byte_valid until the handshake edge, bounded
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok         = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (byte_ready === 1'b1) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    byte_valid = 1'b0;
    if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int exp_addr, input int gap);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) tick();
      send_byte(w[8*k +: 8]);
    end
    chk("write_we", 32'(imem_we), 32'd1);
    chk("write_addr", 32'(imem_addr), 32'(exp_addr));
    chk("write_data", imem_wdata, w);
    chk("write_ready_low", 32'(byte_ready), 32'd0);
  endtask

  initial begin
    int base;
    int n;

    // reset state
    tick();
    tick();
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_hold", 32'(core_hold), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    rst = 1'b0;
    byte_valid = 1'b1;
    tick();
    chk("idle_ready_ignores_valid", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;

    // single word
    start_load(1);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_ready", 32'(byte_ready), 32'd1);
    send_word(32'h0010_0133, 0, 0);
    tick();
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_hold", 32'(core_hold), 32'd0);
    chk("s1_checksum", checksum, 32'h0010_0133);
    chk("s1_we_count", 32'(we_count), 32'd1);
    tick();
    chk("s1_done_sticky", 32'(done), 32'd1);

    // three words with gaps
    start_load(3);
    chk("s3_done_cleared", 32'(done), 32'd0);
    chk("s3_hold", 32'(core_hold), 32'd1);
    send_word(32'h0010_0133, 0, 2);
    send_word(32'h0020_81B3, 1, 1);
    send_word(32'h0000_0013, 2, 3);
    tick();
    chk("s3_done", 32'(done), 32'd1);
    chk("s3_checksum", checksum, 32'h0030_8093);
    chk("s3_we_count", 32'(we_count), 32'd4);
    tick();

    // bad lengths
    base = we_count;
    start_load(0);
    chk("len0_err", 32'(err), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_hold", 32'(core_hold), 32'd1);
    start_load(257);
    chk("len257_err", 32'(err), 32'd1);
    chk("len257_ready", 32'(byte_ready), 32'd0);
    tick();
    chk("badlen_no_write", 32'(we_count - base), 32'd0);

    // timeout after one word and a partial byte
    start_load(2);
    chk("to_err_cleared", 32'(err), 32'd0);
    base = we_count;
    send_word(32'hDEAD_BEEF, 0, 0);
    send_byte(8'hAA);
    n = 0;
    for (int i = 1; i <= 2 * TIMEOUT; i++) begin
      tick();
      if (err === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("to_stall_cycles", 32'(n), 32'(TIMEOUT));
    chk("to_one_write", 32'(we_count - base), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_hold", 32'(core_hold), 32'd1);
    chk("to_ready", 32'(byte_ready), 32'd0);
    start_load(1);
    chk("to_reload_err", 32'(err), 32'd0);
    send_word(32'h0000_0013, 0, 0);
    tick();
    chk("to_reload_done", 32'(done), 32'd1);
    chk("to_reload_checksum", checksum, 32'h0000_0013);
    tick();

    // async reset mid-load
    start_load(2);
    send_word(32'h0040_0213, 0, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_hold", 32'(core_hold), 32'd1);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_ready", 32'(byte_ready), 32'd0);
    chk("ar_addr", 32'(imem_addr), 32'd0);
    chk("ar_wdata", imem_wdata, 32'd0);
    chk("ar_checksum", checksum, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    start_load(1);
    send_word(32'h00A0_0093, 0, 0);
    tick();
    chk("ar_reload_done", 32'(done), 32'd1);
    chk("ar_reload_checksum", checksum, 32'h00A0_0093);
    tick();

    // load_start during RECV ignored
    start_load(2);
    start_load(1);
    chk("ig_busy", 32'(busy), 32'd1);
    send_word(32'h1234_5678, 0, 0);
    tick();
    chk("ig_not_done", 32'(done), 32'd0);
    chk("ig_still_busy", 32'(busy), 32'd1);
    send_word(32'h0F0F_0F0F, 1, 0);
    tick();
    chk("ig_done", 32'(done), 32'd1);
    chk("ig_checksum", checksum, 32'h1D3B_5977);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
